booth_radix4_seq_mult: RTL and testbench
========================================

BOOTH_RADIX4_SEQ_MULT -- requirements
Module: booth_radix4_seq_mult

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: in_valid  input  1  operand pair offered.
REQ-004 SHALL have port: in_ready  output  1  block can accept operands.
REQ-005 SHALL have port: a  input  8  multiplicand, signed two's complement.
REQ-006 SHALL have port: b  input  8  multiplier, signed two's complement (Booth-recoded).
REQ-007 SHALL have port: out_valid  output  1  product available.
REQ-008 SHALL have port: out_ready  input  1  consumer takes product.
REQ-009 SHALL have port: product  output  16  signed a*b.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE with rst_n high; out_valid=1 only in DONE; the two are never both high.
REQ-013 SHALL, on a clk edge with in_valid&&in_ready, capture a and b, clear the 16-bit accumulator, set step=0, and enter RUN.
REQ-014 SHALL, in RUN, perform one radix-4 digit per cycle for step 0..3, using triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
REQ-015 SHALL map triplets as: 000/111 -> 0; 001/010 -> +a; 011 -> +2a; 100 -> -2a; 101/110 -> -a.
REQ-016 SHALL sign-extend a to 16 bits before any doubling or negation, shift the partial product left by 2*step, and add it to the accumulator modulo 2^16.
REQ-017 SHALL enter DONE on the edge that performs step 3, and SHALL present product=accumulator with out_valid=1 exactly 4 cycles after the accept edge.
REQ-018 SHALL hold product and out_valid stable in DONE until out_valid&&out_ready, then enter IDLE on that edge.
REQ-019 SHALL have a maximum throughput of one operation per 6 cycles; new operands are never accepted in the DONE->IDLE cycle.
REQ-020 SHALL ignore in_valid in RUN and DONE; a, b may change freely after the accept edge.
REQ-021 SHALL retain product at its last value in IDLE and RUN; only out_valid qualifies it.
REQ-022 SHALL produce exact results for all 65536 operand pairs; -128*-128 = 16384 needs no saturation.

Reset
REQ-023 SHALL, on a clk edge with rst_n=0, set state=IDLE, step=0, accumulator=0, product=0, out_valid=0 and busy=0.
REQ-024 SHALL drive in_ready=0 while rst_n=0.
REQ-025 SHALL abandon any operation in progress when reset is applied mid-RUN or mid-DONE, with no product emitted afterwards.

Configuration
REQ-026 SHALL, with macro BOOTH_ABORT_EN defined, add port abort (input, 1 bit), whose effect is: abort=1 in RUN or DONE forces IDLE on the next edge, clears out_valid, and leaves product unchanged.
REQ-027 SHALL give abort priority over out_ready when both are high in DONE.
REQ-028 SHALL, without BOOTH_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-029 SHALL define the following in shared package booth_pkg: the state enum typedef (IDLE/RUN/DONE), OPERAND_W=8, PRODUCT_W=16, NUM_DIGITS=4, and a 2-bit magnitude-select typedef (ZERO/ONE/TWO).
REQ-030 SHALL place digit recoding plus partial-product selection/negation in one combinational sub-module booth_pp_gen (inputs: triplet, sign-extended a; output: 16-bit partial product).
REQ-031 SHALL implement step counter, accumulator and FSM in the top module.

Verification
REQ-032 SHALL cover: accept a=3, b=5 -> out_valid 4 cycles after accept, product=16'd15.
REQ-033 SHALL cover: a=-128, b=-128 -> product=16'h4000; a=127, b=-128 -> product=-16256 (16'hC080).
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> product and out_valid stable for all 10 cycles, then IDLE one edge after out_ready=1.
REQ-035 SHALL cover: in_valid pulsed with new operands during RUN -> ignored; first product unchanged; in_ready stays 0 until IDLE.
REQ-036 SHALL cover: rst_n=0 for one edge at RUN step 2 -> next cycle IDLE, in_ready=1, out_valid=0, product=0.
REQ-037 SHALL cover, with BOOTH_ABORT_EN: abort=1 at RUN step 1 -> IDLE next edge, no out_valid; a following 7*-6 yields -42.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and sizes for the radix-4 Booth sequential multiplier.
//   state_t : controller states (IDLE / RUN / DONE)
//   mag_t   : partial-product magnitude select (ZERO / ONE / TWO times a)
package booth_pkg;

  localparam int OPERAND_W  = 8;
  localparam int PRODUCT_W  = 16;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } mag_t;

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth digit recoder and partial-product generator (combinational).
// Ports:
//   triplet : {b[2i+1], b[2i], b[2i-1]} for the current digit
//   a_ext   : multiplicand already sign-extended to PRODUCT_W bits
//   pp      : selected partial product (0, +-a, +-2a), unshifted
module booth_pp_gen
  import booth_pkg::*;
(
  input  logic [2:0]           triplet,
  input  logic [PRODUCT_W-1:0] a_ext,
  output logic [PRODUCT_W-1:0] pp
);

  mag_t                 mag;
  logic                 neg;
  logic [PRODUCT_W-1:0] mag_val;

  always_comb begin
    mag = ZERO;
    neg = 1'b0;
    unique case (triplet)
      3'b000, 3'b111: begin mag = ZERO; neg = 1'b0; end
      3'b001, 3'b010: begin mag = ONE;  neg = 1'b0; end
      3'b011:         begin mag = TWO;  neg = 1'b0; end
      3'b100:         begin mag = TWO;  neg = 1'b1; end
      3'b101, 3'b110: begin mag = ONE;  neg = 1'b1; end
      default:        begin mag = ZERO; neg = 1'b0; end
    endcase
  end

  always_comb begin
    mag_val = '0;
    case (mag)
      ONE:     mag_val = a_ext;
      TWO:     mag_val = a_ext << 1;
      default: mag_val = '0;
    endcase
    pp = neg ? (~mag_val + 1'b1) : mag_val;
  end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential signed 8x8 multiplier, one radix-4 Booth digit per cycle.
// Result appears with out_valid exactly 4 cycles after the accept edge and is
// held until out_valid && out_ready.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready, a, b : operand handshake (signed operands)
//   out_valid/out_ready, product : result handshake (signed product)
//   busy                 : high whenever not IDLE
//   abort                : only when BOOTH_ABORT_EN is defined; drops the
//                          current operation, product left unchanged
module booth_radix4_seq_mult
  import booth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef BOOTH_ABORT_EN
  input  logic                 abort,
`endif
  output logic [PRODUCT_W-1:0] product,
  output logic                 busy
);

  localparam int STEP_W = $clog2(NUM_DIGITS);

  state_t               state;
  logic [STEP_W-1:0]    step;
  logic [PRODUCT_W-1:0] acc;
  logic [OPERAND_W-1:0] a_reg;
  // Multiplier with b[-1]=0 appended; shifted right two bits per digit so
  // the current triplet is always the low three bits.
  logic [OPERAND_W:0]   b_sh;

  logic [PRODUCT_W-1:0] a_ext;
  logic [PRODUCT_W-1:0] pp;
  logic [PRODUCT_W-1:0] acc_next;

  assign a_ext = {{(PRODUCT_W-OPERAND_W){a_reg[OPERAND_W-1]}}, a_reg};

  booth_pp_gen u_pp_gen (
    .triplet (b_sh[2:0]),
    .a_ext   (a_ext),
    .pp      (pp)
  );

  assign acc_next = acc + (pp << {step, 1'b0});

  assign in_ready = (state == IDLE) && rst_n;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      acc       <= '0;
      a_reg     <= '0;
      b_sh      <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else
`ifdef BOOTH_ABORT_EN
    if (abort && (state != IDLE)) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else
`endif
    begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_sh  <= {b, 1'b0};
            acc   <= '0;
            step  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          b_sh <= {2'b00, b_sh[OPERAND_W:2]};
          step <= step + 1'b1;
          if (step == STEP_W'(NUM_DIGITS - 1)) begin
            product   <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Self-checking bench for booth_radix4_seq_mult: directed corner cases plus
// randomized operands compared against plain signed multiplication.
// Abort scenario is compiled in when BOOTH_ABORT_EN is defined.
module tb_booth_radix4_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
`ifdef BOOTH_ABORT_EN
  logic        abort;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  booth_radix4_seq_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BOOTH_ABORT_EN
    .abort     (abort),
`endif
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer operands, return observed product and cycles from accept to out_valid.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] prod, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check_eq("in_ready_before_op", 32'(in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    prod = product;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] prod;
    logic [15:0] held;
    logic [7:0]  ra, rb;
    int          lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
`ifdef BOOTH_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);

    // 3*5, latency
    start_op(8'd3, 8'd5, prod, lat);
    check_eq("lat_3x5", 32'(lat), 32'd4);
    check_eq("prod_3x5", 32'(prod), 32'd15);
    check_eq("busy_done", 32'(busy), 32'd1);
    release_op();
    check_eq("idle_after_3x5", 32'(busy), 32'd0);
    check_eq("ov_after_3x5", 32'(out_valid), 32'd0);
    check_eq("retain_prod_idle", 32'(product), 32'd15);

    // corners
    start_op(8'h80, 8'h80, prod, lat);
    check_eq("prod_m128xm128", 32'(prod), 32'h4000);
    release_op();
    start_op(8'd127, 8'h80, prod, lat);
    check_eq("prod_127xm128", 32'(prod), 32'hC080);
    check_eq("lat_127xm128", 32'(lat), 32'd4);
    release_op();

    // stall in DONE for 10 cycles; in_valid offered meanwhile must be ignored
    start_op(8'hF9, 8'd13, prod, lat);
    held = ref_mul(8'hF9, 8'd13);
    check_eq("prod_stall", 32'(prod), 32'(held));
    in_valid = 1'b1; a = 8'd1; b = 8'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_product", 32'(product), 32'(held));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    release_op();
    check_eq("stall_release_idle", 32'(busy), 32'd0);
    check_eq("stall_release_ov", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    // in_valid pulsed during RUN is ignored
    a = 8'd3; b = 8'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; a = 8'd100; b = 8'hF9;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check_eq("run_in_ready", 32'(in_ready), 32'd0);
      tick(); lat++;
    end
    in_valid = 1'b0;
    check_eq("run_ignore_lat", 32'(lat), 32'd4);
    check_eq("run_ignore_prod", 32'(product), 32'd15);
    release_op();

    // reset at RUN step 2
    a = 8'd9; b = 8'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_product", 32'(product), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) lat++;
    end
    check_eq("midrst_no_output", 32'(lat), 32'd0);

`ifdef BOOTH_ABORT_EN
    start_op(8'd2, 8'd4, prod, lat);
    check_eq("pre_abort_prod", 32'(prod), 32'd8);
    release_op();
    a = 8'd50; b = 8'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_product", 32'(product), 32'd8);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) lat++;
    end
    check_eq("abort_no_output", 32'(lat), 32'd0);
    start_op(8'd7, 8'hFA, prod, lat);
    check_eq("after_abort_7xm6", 32'(prod), 32'hFFD6);
    // abort wins over out_ready in DONE
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    check_eq("abort_done_busy", 32'(busy), 32'd0);
    check_eq("abort_done_prod", 32'(product), 32'hFFD6);
`endif

    // randomized operands against plain signed multiplication
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 8'h80;
        1:       ra = 8'h7F;
        default: ra = 8'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 8'h80;
        1:       rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      start_op(ra, rb, prod, lat);
      check_eq("rand_lat", 32'(lat), 32'd4);
      check_eq("rand_prod", 32'(prod), 32'(ref_mul(ra, rb)));
      repeat ($urandom_range(0, 2)) tick();
      release_op();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
